// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings and default sizing for the ALU sharing arbiter and the
// round-robin arbiter it uses.
package alu_share_arbiter_pkg;

  localparam int DEFAULT_NREQ = 2;
  localparam int DEFAULT_ID_W = 2;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_OPC = 2'b10,
    ALUOP_MOV = 2'b11
  } aluop_e;

  localparam logic [3:0] OPC_MOV  = 4'd1;
  localparam logic [3:0] OPC_ADDI = 4'd2;
  localparam logic [3:0] OPC_SUBI = 4'd3;
  localparam logic [3:0] OPC_ORI  = 4'd4;
  localparam logic [3:0] OPC_ANDI = 4'd5;
  localparam logic [3:0] OPC_XORI = 4'd6;
  localparam logic [3:0] OPC_SLTI = 4'd7;
  localparam logic [3:0] OPC_LI   = 4'd8;
  localparam logic [3:0] OPC_LWI  = 4'd9;
  localparam logic [3:0] OPC_SWI  = 4'd10;

  // Requester index reached 'off' steps after 'base', wrapping at n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps; returns a one-hot grant and its encoded index.
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int ID_W = DEFAULT_ID_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);

  logic found;

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && wrap_idx(int'(ptr), off, NREQ) == i) begin
          grant[i] = 1'b1;
          idx      = ID_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters with a
// two-cycle fixed-latency pipeline. Optional feature: ALU_SHARE_ARB_LOCK_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NREQ      = DEFAULT_NREQ,
  parameter int ID_W      = DEFAULT_ID_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_aluop,
  input  logic [4*NREQ-1:0]         req_opcode,
  input  logic [WORD_SIZE*NREQ-1:0] req_a,
  input  logic [WORD_SIZE*NREQ-1:0] req_b,
`ifdef ALU_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  output logic [1:0]                alu_aluop,
  output logic [3:0]                alu_opcode,
  output logic [WORD_SIZE-1:0]      alu_a,
  output logic [WORD_SIZE-1:0]      alu_b,
  input  logic [WORD_SIZE-1:0]      alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WORD_SIZE-1:0]      rsp_result,
  output logic                      rsp_zero
);

  logic [ID_W-1:0]      rr_ptr;
  logic [NREQ-1:0]      rr_grant;
  logic [ID_W-1:0]      rr_idx;
  logic [NREQ-1:0]      grant;
  logic [ID_W-1:0]      win_idx;
  logic                 lock_hit;
  logic                 accept;

  logic [1:0]           sel_aluop;
  logic [3:0]           sel_opcode;
  logic [WORD_SIZE-1:0] sel_a;
  logic [WORD_SIZE-1:0] sel_b;

  logic                 iss_valid;
  logic [ID_W-1:0]      iss_id;
  logic [1:0]           iss_aluop;
  logic [3:0]           iss_opcode;
  logic [WORD_SIZE-1:0] iss_a;
  logic [WORD_SIZE-1:0] iss_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

`ifdef ALU_SHARE_ARB_LOCK_EN
  logic [NREQ-1:0] lock_oh;
  logic [ID_W-1:0] lock_id;

  // A lock is recorded only when the accepted requester also asserts req_lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_oh <= '0;
      lock_id <= '0;
    end else begin
      lock_oh <= accept ? (grant & req_lock) : '0;
      if (accept) lock_id <= win_idx;
    end
  end
`endif

  always_comb begin
    grant    = rr_grant;
    win_idx  = rr_idx;
    lock_hit = 1'b0;
`ifdef ALU_SHARE_ARB_LOCK_EN
    if (|(lock_oh & req_valid & req_lock)) begin
      grant    = lock_oh;
      win_idx  = lock_id;
      lock_hit = 1'b1;
    end
`endif
    // Grant is combinational, so it is masked to keep req_ready low in reset.
    if (!rst_n) grant = '0;
  end

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_aluop  = '0;
    sel_opcode = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_aluop  = req_aluop[2*i +: 2];
        sel_opcode = req_opcode[4*i +: 4];
        sel_a      = req_a[WORD_SIZE*i +: WORD_SIZE];
        sel_b      = req_b[WORD_SIZE*i +: WORD_SIZE];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= ID_W'(NREQ - 1);
      iss_valid  <= 1'b0;
      iss_id     <= '0;
      iss_aluop  <= '0;
      iss_opcode <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_id     <= win_idx;
        iss_aluop  <= sel_aluop;
        iss_opcode <= sel_opcode;
        iss_a      <= sel_a;
        iss_b      <= sel_b;
        if (!lock_hit) rr_ptr <= win_idx;
      end
    end
  end

  assign alu_aluop  = iss_aluop;
  assign alu_opcode = iss_opcode;
  assign alu_a      = iss_a;
  assign alu_b      = iss_b;

  // Result and flag track the ALU every cycle; rsp_valid marks real operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      rsp_valid  <= iss_valid;
      rsp_id     <= iss_id;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached;
// define ALU_SHARE_ARB_LOCK_EN to also exercise the lock feature.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_aluop;
  logic [4*N-1:0] req_opcode;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
`ifdef ALU_SHARE_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif
  logic [1:0]     alu_aluop;
  logic [3:0]     alu_opcode;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  result;
    logic          zero;
    int            cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] exp_res  [N];
  logic         exp_zero [N];

  alu_share_arbiter #(.WORD_SIZE(W), .NREQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluop  (req_aluop),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ALU_SHARE_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_aluop  (alu_aluop),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the external ALU.
  always_comb begin
    alu_result = '0;
    case (alu_aluop)
      ALUOP_ADD: alu_result = alu_a + alu_b;
      ALUOP_SUB: alu_result = alu_a - alu_b;
      ALUOP_MOV: alu_result = alu_b;
      default: begin
        case (alu_opcode)
          OPC_ADDI, OPC_LWI, OPC_SWI: alu_result = alu_a + alu_b;
          OPC_SUBI: alu_result = alu_a - alu_b;
          OPC_ORI:  alu_result = alu_a | alu_b;
          OPC_ANDI: alu_result = alu_a & alu_b;
          OPC_XORI: alu_result = alu_a ^ alu_b;
          OPC_SLTI: alu_result = W'($signed(alu_a) < $signed(alu_b));
          OPC_LI, OPC_MOV: alu_result = alu_b;
          default:  alu_result = '0;
        endcase
      end
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id",      64'(rsp_id),     64'(mon_e.id));
        check("rsp_result",  64'(rsp_result), 64'(mon_e.result));
        check("rsp_zero",    64'(rsp_zero),   64'(mon_e.zero));
        check("rsp_latency", 64'(cyc),        64'(mon_e.cyc));
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic z);
    req_aluop[2*i +: 2]  = op;
    req_opcode[4*i +: 4] = opc;
    req_a[W*i +: W]      = a;
    req_b[W*i +: W]      = b;
    exp_res[i]           = res;
    exp_zero[i]          = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives req_valid for the current cycle, checks the grant and queues the
  // expected response of the winner two cycles later.
  task automatic drive(input logic [N-1:0] valid, input logic [N-1:0] want, input bit push);
    req_valid = valid;
    #3;
    check("req_ready", 64'(req_ready), 64'(want));
    if (push) begin
      for (int i = 0; i < N; i++) begin
        if (want[i]) sb.push_back('{id: IW'(i), result: exp_res[i], zero: exp_zero[i], cyc: cyc + 2});
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),  64'd0);
    check({tag, "_alu_aluop"},  64'(alu_aluop),  64'd0);
    check({tag, "_alu_opcode"}, 64'(alu_opcode), 64'd0);
    check({tag, "_alu_a"},      64'(alu_a),      64'd0);
    check({tag, "_alu_b"},      64'(alu_b),      64'd0);
    check({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    check({tag, "_rsp_id"},     64'(rsp_id),     64'd0);
    check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    check({tag, "_rsp_zero"},   64'(rsp_zero),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_aluop  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
`ifdef ALU_SHARE_ARB_LOCK_EN
    req_lock   = '0;
`endif
    set_req(0, ALUOP_ADD, OPC_MOV,  32'd5,          32'd7, 32'd12, 1'b0);
    set_req(1, ALUOP_OPC, OPC_SLTI, 32'hFFFF_FFFF,  32'd1, 32'd1,  1'b0);
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #4;
    check_all_zero("reset");
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;

    // Both requesting: grants alternate starting at requester 0.
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    end

    // New operations: SUB to zero, SLTI equal operands, then a MOV.
    tick();
    set_req(0, ALUOP_SUB, OPC_MOV,  32'd3, 32'd3, 32'd0, 1'b1);
    set_req(1, ALUOP_OPC, OPC_SLTI, 32'd9, 32'd9, 32'd0, 1'b1);
    drive(2'b11, 2'b01, 1'b1);
    tick();
    drive(2'b11, 2'b10, 1'b1);
    tick();
    set_req(0, ALUOP_MOV, OPC_MOV, 32'd1, 32'hABCD_1234, 32'hABCD_1234, 1'b0);
    drive(2'b01, 2'b01, 1'b1);

    // Requester 1 alone for three cycles, then idle.
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(2'b10, 2'b10, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(2'b00, 2'b00, 1'b0);
    end
    check("idle_rsp_valid",  64'(rsp_valid),  64'd0);
    check("idle_alu_a_hold", 64'(alu_a),      64'd9);
    check("idle_alu_op_hold", 64'(alu_opcode), 64'(OPC_SLTI));

    // Reset one cycle after an acceptance: the operation must vanish.
    tick();
    drive(2'b01, 2'b01, 1'b0);
    tick();
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();
    drive(2'b11, 2'b01, 1'b1);
    tick();
    drive(2'b00, 2'b00, 1'b0);

`ifdef ALU_SHARE_ARB_LOCK_EN
    // Requester 1 holds the lock for three operations, then releases.
    tick();
    req_lock = 2'b10;
    drive(2'b10, 2'b10, 1'b1);
    tick();
    drive(2'b11, 2'b10, 1'b1);
    tick();
    drive(2'b11, 2'b10, 1'b1);
    tick();
    req_lock = 2'b00;
    drive(2'b11, 2'b01, 1'b1);
    tick();
    drive(2'b00, 2'b00, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #4;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters (e.g. fetch PC-increment, execute, branch compare) using round-robin arbitration.
- Each accepted request is registered into an issue stage that drives the ALU. The ALU result and zero flag are registered and returned with the requester ID.
- Fully pipelined: one operation per cycle, fixed latency.
- The ALU sits outside this block; the arbiter drives its operand/control inputs and samples its outputs.

Parameters:
- WORD_SIZE, 32, operand/result width.
- NREQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of the response ID; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  grant/accept; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
- req_aluop  in  2*NREQ  ALUOp per requester; slice i is [2i+1:2i].
- req_opcode  in  4*NREQ  Opcode per requester.
- req_a  in  WORD_SIZE*NREQ  operand A (R2) per requester.
- req_b  in  WORD_SIZE*NREQ  operand B (R3, or extended immediate) per requester.
- alu_aluop  out  2  to ALU ALUOp.
- alu_opcode  out  4  to ALU Opcode.
- alu_a  out  WORD_SIZE  to ALU R2.
- alu_b  out  WORD_SIZE  to ALU R3.
- alu_result  in  WORD_SIZE  from ALU R1.
- alu_zero  in  1  from ALU Zero.
- rsp_valid  out  1  response valid; single-cycle pulse per operation.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  WORD_SIZE  registered ALU result.
- rsp_zero  out  1  registered zero flag.

Behaviour:
- Reset (async assert, sync deassert by the integrator): every issue and response register clears to 0; rr_ptr = NREQ-1, so requester 0 has top priority after reset. Outputs alu_* = 0, rsp_* = 0, req_ready = 0.
- Grant is combinational:
  - Search starts at (rr_ptr+1) mod NREQ and wraps.
  - The first requester found with req_valid=1 gets req_ready=1.
  - At most one bit of req_ready is high. If no req_valid is high, req_ready = 0.
- Acceptance, cycle N: the selected aluop/opcode/a/b and the requester ID load into the issue registers; iss_valid <= 1; rr_ptr <= winner. With no acceptance, iss_valid <= 0 and rr_ptr holds.
- Cycle N+1: alu_* outputs are driven directly from the issue registers. At the end of N+1, rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_id <= iss_id, rsp_valid <= iss_valid.
- Cycle N+2: rsp_valid=1 with the data. Latency from acceptance to rsp_valid is fixed at 2 cycles.
- Throughput: one acceptance per cycle; back-to-back acceptances give back-to-back responses. There is no response backpressure; consumers must take rsp_* when rsp_valid=1.
- When iss_valid=0, the alu_* outputs hold their last values (no toggling). rsp_valid is 0 in that case, but rsp_result still tracks the ALU.
- Requesters must hold operands stable while req_valid=1 and req_ready=0. They may deassert req_valid at any time before acceptance.
- Reset mid-operation: in-flight issue/response entries are discarded, and no rsp_valid follows after reset release.
- Arithmetic is not interpreted here; width rules come from the ALU.

Optional Feature:
- Macro: ALU_SHARE_ARB_LOCK_EN.
- Enabled:
  - Adds input req_lock (NREQ bits).
  - If the accepted requester has req_lock=1 in its acceptance cycle, it is granted unconditionally in the next cycle if it asserts req_valid, overriding round-robin.
  - rr_ptr does not advance while locked.
  - The lock releases on the first cycle the owner's req_valid=0 or req_lock=0; normal RR then resumes from the owner.
- Disabled: the port is absent and arbitration is pure round-robin.

Decomposition:
- Shared package holds:
  - ALUOp encodings: ADD=2'b00, SUB=2'b01, OPC=2'b10, MOV=2'b11.
  - The 4-bit opcode constants: MOV, ADDI, SUBI, ORI, ANDI, XORI, SLTI, LI, LWI, SWI.
  - The default NREQ/ID_W values.
- One sub-module is natural: rr_arbiter (req vector, pointer → one-hot grant plus encoded index), purely combinational, reused by other shared resources.

Test Plan:
- After reset, req_valid=2'b11 held for 4 cycles → grants alternate 0,1,0,1; rsp_id in the same order starting 2 cycles after the first grant.
- Requester 0: aluop=00, a=5, b=7 → rsp_valid at N+2 with rsp_result=12, rsp_zero=0, rsp_id=0.
- Requester 1: aluop=10, opcode=0111, a=32'hFFFFFFFF, b=1 → rsp_result=1 (signed -1 < 1); with a=b=9 → rsp_zero=1.
- Only requester 1 requests for 3 cycles → req_ready[1]=1 every cycle and 3 consecutive rsp_valid pulses. req_valid=0 → rsp_valid low 2 cycles later.
- rst_n asserted one cycle after an acceptance → no rsp_valid appears; all outputs return to 0 immediately; the first grant after release goes to requester 0.
- ALU_SHARE_ARB_LOCK_EN: requester 1 locks for 3 operations while requester 0 requests → grants 1,1,1,then 0.
